// File: rtl/inst_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package inst_encoder_pkg;
`include "inst_opcodes.sv"

    localparam logic [6:0] OP_LUI       = `OPC_LUI;
    localparam logic [6:0] OP_AUIPC     = `OPC_AUIPC;
    localparam logic [6:0] OP_JAL       = `OPC_JAL;
    localparam logic [6:0] OP_JALR      = `OPC_JALR;
    localparam logic [6:0] OP_BRANCH    = `OPC_BRANCH;
    localparam logic [6:0] OP_LOAD      = `OPC_LOAD;
    localparam logic [6:0] OP_STORE     = `OPC_STORE;
    localparam logic [6:0] OP_ARITH_IMM = `OPC_ARITH_IMM;
    localparam logic [6:0] OP_ARITH     = `OPC_ARITH;
    localparam logic [6:0] OP_SYSTEM    = `OPC_SYSTEM;

    localparam logic [31:0] ECALL_INST = 32'h0000_0073;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    // True when v, read as two's complement, fits in a signed field of 'bits' width.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic signed [31:0] lim;
        lim = 32'sd1 <<< (bits - 32'd1);
        return ($signed(v) >= -lim) && ($signed(v) < lim);
    endfunction
endpackage

// File: rtl/inst_opcodes.sv
// RV32I major opcode values shared across the encoder slice.
// Guarded so it can be both compiled on its own and pulled into the package.
`ifndef INST_OPCODES_SV
`define INST_OPCODES_SV
`define OPC_LUI       7'b0110111
`define OPC_AUIPC     7'b0010111
`define OPC_JAL       7'b1101111
`define OPC_JALR      7'b1100111
`define OPC_BRANCH    7'b1100011
`define OPC_LOAD      7'b0000011
`define OPC_STORE     7'b0100011
`define OPC_ARITH_IMM 7'b0010011
`define OPC_ARITH     7'b0110011
`define OPC_SYSTEM    7'b1110011
`endif

// File: rtl/inst_packer.sv
// Combinational RV32I field packer: places fields per format and flags
// immediates that cannot be represented, plus unknown opcodes.
module inst_packer
    import inst_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        legal
);
    always_comb begin
        inst  = '0;
        legal = 1'b0;
        case (opcode)
            OP_ARITH: begin
                inst  = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
            OP_ARITH_IMM, OP_LOAD, OP_JALR: begin
                inst  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = fits_signed(imm, 12);
            end
            OP_STORE: begin
                inst  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = fits_signed(imm, 12);
            end
            OP_BRANCH: begin
                inst  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal = fits_signed(imm, 13) && !imm[0];
            end
            OP_LUI, OP_AUIPC: begin
                inst  = {imm[31:12], rd, opcode};
                legal = (imm[11:0] == 12'h000);
            end
            OP_JAL: begin
                inst  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = fits_signed(imm, 21) && !imm[0];
            end
            // Every SYSTEM request is treated as ECALL; the operand fields are don't-care.
            OP_SYSTEM: begin
                inst  = ECALL_INST;
                legal = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: one-deep output register with ready/valid on both
// sides, address tagging, error/encode counters and a RUN/DONE stop on ECALL.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [15:0] enc_count,
    output logic [15:0] err_count
);
    state_t      state;
    logic [31:0] pk_inst;
    logic        pk_legal;
    logic        accept;
    logic        out_fire;

    inst_packer u_packer (
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .inst   (pk_inst),
        .legal  (pk_legal)
    );

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // out_addr always names the slot of the pending (or next) output, so it
    // only advances on an output handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_addr  <= BASE_ADDR;
            err       <= 1'b0;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            err <= 1'b0;
            if (restart) begin
                state     <= RUN;
                out_valid <= 1'b0;
                out_addr  <= BASE_ADDR;
            end else begin
                if (out_fire) begin
                    out_valid <= 1'b0;
                    out_addr  <= out_addr + 32'd4;
                    if (enc_count != 16'hFFFF)
                        enc_count <= enc_count + 16'd1;
                end
                // A same-cycle acceptance overrides the clear above: no bubble.
                if (accept) begin
                    if (pk_legal) begin
                        out_valid <= 1'b1;
                        out_inst  <= pk_inst;
                        if (in_opcode == OP_SYSTEM)
                            state <= DONE;
                    end else begin
                        err <= 1'b1;
                        if (err_count != 16'hFFFF)
                            err_count <= err_count + 16'd1;
                    end
                end
            end
        end
    end
endmodule
